// File: rtl/instr_fetch_decode_pkg.sv
// instr_fetch_decode_pkg: shared widths, instruction field positions, opcodes and fetch/decode state encoding
package instr_fetch_decode_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W = 6;
  localparam int OPCODE_W = 6;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 6'h3F;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_EXEC, S_HALTED, S_ERROR
  } state_t;
endpackage

// File: rtl/instr_decode_fields.sv
// instr_decode_fields: splits a 32-bit word (instr) into opcode, rs, rt, rd, shamt and funct
module instr_decode_fields
  import instr_fetch_decode_pkg::*;
(
  input  logic [DATA_W-1:0]     instr,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] shamt,
  output logic [FUNCT_W-1:0]    funct
);
  assign opcode = instr[OPCODE_LSB +: OPCODE_W];
  assign rs     = instr[RS_LSB +: REG_ADDR_W];
  assign rt     = instr[RT_LSB +: REG_ADDR_W];
  assign rd     = instr[RD_LSB +: REG_ADDR_W];
  assign shamt  = instr[SHAMT_LSB +: REG_ADDR_W];
  assign funct  = instr[FUNCT_LSB +: FUNCT_W];
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC + memory fetch (MEM_*), R-type field decode, control-unit sequencing (CU_RST/EXEC_DONE), counters and status
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [DATA_W-1:0]   RESET_PC     = 32'h0000_0000,
  parameter int                  EXEC_TIMEOUT = 64,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [DATA_W-1:0]     MEM_ADDR,
  output logic                  MEM_READ,
  input  logic [DATA_W-1:0]     MEM_DATA,
  input  logic                  MEM_READY,
  output logic [OPCODE_W-1:0]   OPCODE,
  output logic [REG_ADDR_W-1:0] ADDR_R1,
  output logic [REG_ADDR_W-1:0] ADDR_R2,
  output logic [REG_ADDR_W-1:0] ADDR_W,
  output logic [REG_ADDR_W-1:0] SHAMT,
  output logic [FUNCT_W-1:0]    FUNCT,
  output logic                  CU_RST,
  input  logic                  EXEC_DONE,
  output logic [DATA_W-1:0]     PC,
  output logic [15:0]           INSTR_COUNT,
  output logic [7:0]            ILLEGAL_COUNT,
  output logic                  BUSY,
  output logic                  HALTED,
  output logic                  ERROR
);
  localparam int WD_W = $clog2(EXEC_TIMEOUT + 1);
  state_t state, state_nx;
  logic [DATA_W-1:0] ir;
  logic [WD_W-1:0] wdog, wdog_inc;
  logic wd_hit, retire, skip;
  instr_decode_fields u_fields (
    .instr(ir), .opcode(OPCODE), .rs(ADDR_R1), .rt(ADDR_R2),
    .rd(ADDR_W), .shamt(SHAMT), .funct(FUNCT)
  );
  assign wdog_inc = wdog + WD_W'(1);
  assign wd_hit   = wdog_inc == WD_W'(EXEC_TIMEOUT);
  assign retire   = state == S_EXEC && EXEC_DONE;
  assign skip     = state == S_DECODE && OPCODE != HALT_OPCODE && OPCODE != OP_RTYPE;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = START ? S_FETCH : S_IDLE;
      S_FETCH:  state_nx = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = OPCODE == HALT_OPCODE ? S_HALTED : OPCODE != OP_RTYPE ? S_FETCH : S_ISSUE;
      S_ISSUE:  state_nx = S_EXEC;
      S_EXEC:   state_nx = EXEC_DONE ? S_FETCH : wd_hit ? S_ERROR : S_EXEC;
      default:  state_nx = state;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      PC            <= RESET_PC;
      ir            <= '0;
      wdog          <= '0;
      INSTR_COUNT   <= '0;
      ILLEGAL_COUNT <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && MEM_READY) ir <= MEM_DATA;
      if (retire || skip) PC <= PC + 32'd4;
      if (retire && !(&INSTR_COUNT)) INSTR_COUNT <= INSTR_COUNT + 16'd1;
      if (skip && !(&ILLEGAL_COUNT)) ILLEGAL_COUNT <= ILLEGAL_COUNT + 8'd1;
      wdog <= state == S_EXEC ? wdog_inc : '0;
    end
  end
  assign MEM_ADDR = PC;
  assign MEM_READ = state == S_FETCH;
  assign CU_RST   = state != S_ISSUE;
  assign HALTED   = state == S_HALTED;
  assign ERROR    = state == S_ERROR;
  assign BUSY     = !(state == S_IDLE || HALTED || ERROR);
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: randomized scoreboard bench with a program-level reference model
module tb_instr_fetch_decode;
  logic CLK = 0, RST = 1, START = 0;
  logic [31:0] MEM_ADDR, MEM_DATA = 0, PC;
  logic MEM_READ, MEM_READY = 0, CU_RST, EXEC_DONE = 0, BUSY, HALTED, ERROR;
  logic [5:0] OPCODE, FUNCT;
  logic [4:0] ADDR_R1, ADDR_R2, ADDR_W, SHAMT;
  logic [15:0] INSTR_COUNT;
  logic [7:0] ILLEGAL_COUNT;
  logic w_start = 0, w_mem_read, w_cu_rst, w_busy, w_halted, w_error;
  logic [31:0] w_mem_addr, w_mem_data, w_pc;
  logic [5:0] w_opcode, w_funct;
  logic [4:0] w_r1, w_r2, w_rw, w_shamt;
  logic [15:0] w_instr_count;
  logic [7:0] w_illegal_count;
  localparam logic [31:0] ADD_W = 32'h0243_F820, HALT_W = 32'hFC00_0000;
  localparam logic [124:0] RST_OUTS = {32'h0, 1'b0, 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 6'h0, 1'b1, 32'h0, 16'h0, 8'h0, 3'b000};
  int n_vec = 0, n_err = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_fetch [$];
  logic [63:0] exp_issue [$];
  logic [31:0] exp_pc;
  int exp_ret, exp_ill;
  int mem_stall = 0, stall_cnt = 0, exec_delay = 0, exec_cnt = 0;
  bit noise = 0, wait_exec = 0, in_req = 0, prev_cu_low = 0;
  logic [31:0] req_addr;
  logic [63:0] iss;

  instr_fetch_decode dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ),
    .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY), .OPCODE(OPCODE), .ADDR_R1(ADDR_R1),
    .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .SHAMT(SHAMT), .FUNCT(FUNCT), .CU_RST(CU_RST),
    .EXEC_DONE(EXEC_DONE), .PC(PC), .INSTR_COUNT(INSTR_COUNT), .ILLEGAL_COUNT(ILLEGAL_COUNT),
    .BUSY(BUSY), .HALTED(HALTED), .ERROR(ERROR)
  );
  assign w_mem_data = w_mem_addr == 32'hFFFF_FFFC ? ADD_W : HALT_W;
  instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RST(RST), .START(w_start), .MEM_ADDR(w_mem_addr), .MEM_READ(w_mem_read),
    .MEM_DATA(w_mem_data), .MEM_READY(1'b1), .OPCODE(w_opcode), .ADDR_R1(w_r1),
    .ADDR_R2(w_r2), .ADDR_W(w_rw), .SHAMT(w_shamt), .FUNCT(w_funct), .CU_RST(w_cu_rst),
    .EXEC_DONE(1'b1), .PC(w_pc), .INSTR_COUNT(w_instr_count), .ILLEGAL_COUNT(w_illegal_count),
    .BUSY(w_busy), .HALTED(w_halted), .ERROR(w_error)
  );
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : HALT_W;
  endfunction

  function automatic logic [124:0] outs();
    return {MEM_ADDR, MEM_READ, OPCODE, ADDR_R1, ADDR_R2, ADDR_W, SHAMT, FUNCT, CU_RST,
            PC, INSTR_COUNT, ILLEGAL_COUNT, BUSY, HALTED, ERROR};
  endfunction

  // Program-level reference: walk memory word by word, classify each, and record
  // the fetch addresses and issued instructions the DUT must produce.
  task automatic model_run(input logic [31:0] start_pc, input bit stop_at_issue);
    logic [31:0] pc, w;
    pc = start_pc;
    exp_ret = 0;
    exp_ill = 0;
    for (int s = 0; s < 4096; s++) begin
      w = mem_rd(pc);
      exp_fetch.push_back(pc);
      if (w[31:26] == 6'h3F) break;
      if (w[31:26] != 6'h00) begin
        exp_ill = exp_ill == 255 ? 255 : exp_ill + 1;
        pc = pc + 4;
        continue;
      end
      exp_issue.push_back({pc, w});
      if (stop_at_issue) break;
      exp_ret = exp_ret == 65535 ? 65535 : exp_ret + 1;
      pc = pc + 4;
    end
    exp_pc = pc;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1;
    START = 0;
    w_start = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1;
    @(negedge CLK);
    START = 0;
  endtask

  task automatic wait_for_halt(input int limit);
    for (int i = 0; i < limit && !HALTED; i++) @(negedge CLK);
    check("halt_reached", HALTED, 1'b1);
  endtask

  task automatic wait_cu_low(input int limit);
    for (int i = 0; i < limit && CU_RST; i++) @(negedge CLK);
    check("issue_reached", CU_RST, 1'b0);
  endtask

  task automatic check_final(input string name);
    check(name, {PC, INSTR_COUNT, ILLEGAL_COUNT, HALTED, BUSY, ERROR},
          {exp_pc, 16'(exp_ret), 8'(exp_ill), 1'b1, 1'b0, 1'b0});
    check("sb_drain", exp_fetch.size() + exp_issue.size(), 0);
  endtask

  always @(negedge CLK) begin
    MEM_READY = 0;
    if (noise) begin
      MEM_READY = 1'($urandom);
      MEM_DATA = $urandom;
    end
    if (MEM_READ) begin
      MEM_READY = 0;
      if (stall_cnt == 0) begin
        MEM_READY = 1;
        MEM_DATA = mem_rd(MEM_ADDR);
        stall_cnt = mem_stall < 0 ? int'($urandom_range(0, 3)) : mem_stall;
      end else stall_cnt--;
    end
  end

  always @(negedge CLK) begin
    EXEC_DONE = noise ? 1'($urandom) : 1'b0;
    if (RST) wait_exec = 0;
    else if (wait_exec) begin
      EXEC_DONE = 0;
      if (exec_cnt == 0) begin
        EXEC_DONE = 1;
        wait_exec = 0;
      end else exec_cnt--;
    end
    if (!CU_RST) begin
      wait_exec = 1;
      exec_cnt = exec_delay < 0 ? int'($urandom_range(0, 4)) : exec_delay;
    end
  end

  always @(negedge CLK) begin
    if (MEM_READ) begin
      if (!in_req) begin
        if (exp_fetch.size() != 0) req_addr = exp_fetch.pop_front();
        else req_addr = ~MEM_ADDR;
        check("fetch_addr", MEM_ADDR, req_addr);
      end else check("fetch_addr_stable", MEM_ADDR, req_addr);
    end
    in_req = MEM_READ;
    if (prev_cu_low) check("cu_rst_one_cycle", CU_RST, 1'b1);
    else if (!CU_RST) begin
      if (exp_issue.size() != 0) iss = exp_issue.pop_front();
      else iss = ~{MEM_ADDR, OPCODE, ADDR_R1, ADDR_R2, ADDR_W, SHAMT, FUNCT};
      check("issue", {MEM_ADDR, OPCODE, ADDR_R1, ADDR_R2, ADDR_W, SHAMT, FUNCT}, iss);
    end
    prev_cu_low = !CU_RST;
  end

  initial begin
    do_reset();
    check("reset_outs", outs(), RST_OUTS);

    mem.delete();
    mem[0] = ADD_W;
    mem[4] = 32'h2000_0000;
    mem[8] = HALT_W;
    model_run(0, 0);
    pulse_start();
    check("start_to_read", {MEM_READ, MEM_ADDR}, {1'b1, 32'h0});
    @(negedge CLK);
    check("add_fields", {OPCODE, ADDR_R1, ADDR_R2, ADDR_W, SHAMT, FUNCT},
          {6'd0, 5'd18, 5'd3, 5'd31, 5'd0, 6'h20});
    @(negedge CLK);
    check("issue_cycle", CU_RST, 1'b0);
    @(negedge CLK);
    check("exec_pc_held", {PC, CU_RST}, {32'h0, 1'b1});
    @(negedge CLK);
    check("retire_4cyc", {MEM_READ, PC, INSTR_COUNT}, {1'b1, 32'd4, 16'd1});
    wait_for_halt(100);
    check_final("illegal_then_halt");
    check("halt_pc", PC, 32'd8);
    pulse_start();
    repeat (2) @(negedge CLK);
    check("halt_sticky", {HALTED, MEM_READ, BUSY, PC}, {1'b1, 1'b0, 1'b0, 32'd8});

    do_reset();
    mem.delete();
    mem[0] = ADD_W;
    mem[4] = HALT_W;
    stall_cnt = 5;
    model_run(0, 0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {MEM_READ, MEM_ADDR, ADDR_R1}, {1'b1, 32'h0, 5'h0});
      @(negedge CLK);
    end
    @(negedge CLK);
    check("stall_capture", {MEM_READ, ADDR_R1}, {1'b0, 5'd18});
    wait_for_halt(100);
    check_final("stall_run");

    do_reset();
    mem.delete();
    mem[0] = ADD_W;
    exec_delay = 1000;
    model_run(0, 1);
    pulse_start();
    wait_cu_low(20);
    repeat (64) @(negedge CLK);
    check("timeout_edge", {ERROR, BUSY}, {1'b0, 1'b1});
    @(negedge CLK);
    check("timeout_error", {ERROR, BUSY, HALTED}, {1'b1, 1'b0, 1'b0});
    pulse_start();
    repeat (2) @(negedge CLK);
    check("error_sticky", {ERROR, MEM_READ, PC, INSTR_COUNT}, {1'b1, 1'b0, 32'h0, 16'h0});
    check("sb_drain", exp_fetch.size() + exp_issue.size(), 0);

    do_reset();
    stall_cnt = 10;
    exp_fetch.push_back(0);
    pulse_start();
    repeat (3) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    check("rst_mid_fetch", outs(), RST_OUTS);
    stall_cnt = 0;
    model_run(0, 1);
    pulse_start();
    wait_cu_low(20);
    repeat (2) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    check("rst_mid_exec", outs(), RST_OUTS);
    check("sb_drain", exp_fetch.size() + exp_issue.size(), 0);
    exec_delay = 0;

    do_reset();
    mem.delete();
    for (int i = 0; i < 260; i++) mem[32'(4 * i)] = {6'(1 + i % 62), 26'($urandom)};
    mem[1040] = HALT_W;
    model_run(0, 0);
    pulse_start();
    wait_for_halt(1000);
    check_final("illegal_saturate");

    mem_stall = -1;
    exec_delay = -1;
    for (int r = 0; r < 4; r++) begin
      noise = 0;
      do_reset();
      mem.delete();
      for (int i = 0; i < 24; i++)
        mem[32'(4 * i)] = $urandom_range(0, 9) < 7 ? {6'h00, 26'($urandom)}
                                                   : {6'($urandom_range(1, 62)), 26'($urandom)};
      mem[96] = {6'h3F, 26'($urandom)};
      stall_cnt = 1;
      noise = 1;
      model_run(0, 0);
      pulse_start();
      wait_for_halt(2000);
      check_final("random_program");
    end
    noise = 0;
    mem_stall = 0;
    exec_delay = 0;

    do_reset();
    check("wrap_reset_pc", {w_pc, w_mem_addr}, {32'hFFFF_FFFC, 32'hFFFF_FFFC});
    @(negedge CLK);
    w_start = 1;
    @(negedge CLK);
    w_start = 0;
    for (int i = 0; i < 20 && !w_halted; i++) @(negedge CLK);
    check("pc_wrap", {w_halted, w_pc, w_instr_count, w_illegal_count}, {1'b1, 32'h0, 16'd1, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
